// File: rtl/aoi22_pipe_pkg.sv
// Shared mode encoding and the bitwise four-input AND-OR / OR-AND evaluator
// used by the aoi22_pipe datapath.
package aoi_pkg;

    typedef enum logic [1:0] {
        AOI22 = 2'd0,
        AO22  = 2'd1,
        OAI22 = 2'd2,
        OA22  = 2'd3
    } aoi_mode_t;

    // Widest operand the evaluator handles; callers zero-extend and slice.
    localparam int AOI_MAX_WIDTH = 64;

    typedef logic [AOI_MAX_WIDTH-1:0] aoi_word_t;

    function automatic aoi_word_t aoi_eval(
        input aoi_mode_t mode,
        input aoi_word_t a1,
        input aoi_word_t a2,
        input aoi_word_t b1,
        input aoi_word_t b2
    );
        aoi_word_t and_or;
        aoi_word_t or_and;
        aoi_word_t res;
        and_or = (a1 & a2) | (b1 & b2);
        or_and = (a1 | a2) & (b1 | b2);
        case (mode)
            AOI22:   res = ~and_or;
            AO22:    res = and_or;
            OAI22:   res = ~or_and;
            default: res = or_and;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/aoi22_pipe_stage.sv
// One bubble-collapsing pipeline register: valid/result/mode flops with a
// local ready term that lets an empty stage absorb data during a stall.
module aoi_pipe_stage
    import aoi_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_y,
    input  aoi_mode_t        prev_m,
    input  logic             next_ready,
    output logic             valid,
    output logic [WIDTH-1:0] y,
    output aoi_mode_t        m,
    output logic             ready
);

    logic             valid_reg;
    logic [WIDTH-1:0] y_reg;
    aoi_mode_t        m_reg;

    assign ready = ~valid_reg | next_ready;

    // Payload only moves with a real item so an emptied stage keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            y_reg     <= '0;
            m_reg     <= AOI22;
        end else if (ready) begin
            valid_reg <= prev_valid;
            if (prev_valid) begin
                y_reg <= prev_y;
                m_reg <= prev_m;
            end
        end
    end

    assign valid = valid_reg;
    assign y     = y_reg;
    assign m     = m_reg;

endmodule

// File: rtl/aoi22_pipe.sv
// WIDTH-bit mode-selectable AOI22/AO22/OAI22/OA22 evaluated at the input and
// retimed through DEPTH bubble-collapsing stages with valid/ready flow control.
module aoi22_pipe
    import aoi_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_mode,
    input  logic [WIDTH-1:0]           in_a1,
    input  logic [WIDTH-1:0]           in_a2,
    input  logic [WIDTH-1:0]           in_b1,
    input  logic [WIDTH-1:0]           in_b2,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_y,
    output logic [1:0]                 out_mode,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    aoi_word_t        eval_full;
    logic [WIDTH-1:0] eval_y;
    aoi_mode_t        eval_m;

    assign eval_m    = aoi_mode_t'(in_mode);
    assign eval_full = aoi_eval(eval_m,
                                aoi_word_t'(in_a1), aoi_word_t'(in_a2),
                                aoi_word_t'(in_b1), aoi_word_t'(in_b2));
    assign eval_y    = eval_full[WIDTH-1:0];

    if (WIDTH < AOI_MAX_WIDTH) begin : g_pad
        logic unused_hi;
        assign unused_hi = &{1'b0, eval_full[AOI_MAX_WIDTH-1:WIDTH]};
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic             prev_valid;
        logic [WIDTH-1:0] prev_y;
        aoi_mode_t        prev_m;
        logic             next_ready;
        logic             stage_valid;
        logic [WIDTH-1:0] stage_y;
        aoi_mode_t        stage_m;
        logic             stage_ready;

        if (gi == 0) begin : g_head
            assign prev_valid = in_valid;
            assign prev_y     = eval_y;
            assign prev_m     = eval_m;
        end else begin : g_body
            assign prev_valid = g_stage[gi-1].stage_valid;
            assign prev_y     = g_stage[gi-1].stage_y;
            assign prev_m     = g_stage[gi-1].stage_m;
        end

        // Ready ripples back from the output through every stage.
        if (gi == DEPTH - 1) begin : g_tail
            assign next_ready = out_ready;
        end else begin : g_link
            assign next_ready = g_stage[gi+1].stage_ready;
        end

        aoi_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .prev_valid (prev_valid),
            .prev_y     (prev_y),
            .prev_m     (prev_m),
            .next_ready (next_ready),
            .valid      (stage_valid),
            .y          (stage_y),
            .m          (stage_m),
            .ready      (stage_ready)
        );
    end

    assign in_ready  = g_stage[0].stage_ready & rst_n;
    assign out_valid = g_stage[DEPTH-1].stage_valid;
    assign out_y     = g_stage[DEPTH-1].stage_y;
    assign out_mode  = g_stage[DEPTH-1].stage_m;

    logic             in_fire;
    logic             out_fire;
    logic [OCC_W-1:0] occ_reg;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_reg <= '0;
        end else if (in_fire && !out_fire) begin
            occ_reg <= occ_reg + OCC_W'(1);
        end else if (!in_fire && out_fire) begin
            occ_reg <= occ_reg - OCC_W'(1);
        end
    end

    assign occupancy = occ_reg;

endmodule
